// File: rtl/tfm_sched.sv
// Twiddle-path sequencer for a radix-2 DIF FFT.
// It accepts butterfly operands, walks the stage and butterfly counters,
// issues twiddle ROM addresses and multiplier enables, then counts the
// multiplier results until the frame is complete.
module tfm_sched #(
  parameter int N_LOG2      = 6,
  parameter int ADDR_WIDTH  = N_LOG2 - 1,
  parameter int TFM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  rom_rd_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  tfm_en,
  input  logic                  tfm_out_val,
  output logic [N_LOG2-1:0]     stage,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned N     = 1 << N_LOG2;
  localparam int unsigned HALF  = N / 2;
  localparam int unsigned TOTAL = N_LOG2 * HALF;
  localparam int unsigned RW    = $clog2(TOTAL + 1);

  // Reject parameter sets the counters and address math are not sized for.
  if (N_LOG2 < 2 || N_LOG2 > 12 || TFM_LATENCY < 1) begin : g_param_chk
    $error("tfm_sched: unsupported N_LOG2/TFM_LATENCY");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] bfly_q;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [N_LOG2-1:0]     stage_q;
  logic [RW-1:0]         res_cnt_q;
  logic                  in_ready_q;
  logic                  tfm_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic                  accept;
  logic                  last_bfly;
  logic                  last_stage;
  logic                  res_full;
  logic                  res_last;
  logic [ADDR_WIDTH-1:0] addr_mask;
  logic [ADDR_WIDTH-1:0] addr_calc;
  int unsigned           span;

  assign accept     = in_valid & in_ready_q;
  assign last_bfly  = (bfly_q == ADDR_WIDTH'(HALF - 1));
  assign last_stage = (stage_q == N_LOG2'(N_LOG2 - 1));
  assign res_full   = (res_cnt_q == RW'(TOTAL));
  assign res_last   = (res_cnt_q == RW'(TOTAL - 1));

  // Twiddle index for the current butterfly: the low bits of bfly that
  // survive at this stage, scaled by 2**stage.
  always_comb begin
    span      = N >> (32'(stage_q) + 32'd1);
    addr_mask = ADDR_WIDTH'(span - 32'd1);
    addr_calc = (bfly_q & addr_mask) << stage_q;
  end

  // Frame sequencer: state, counters, registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      bfly_q      <= '0;
      addr_hold_q <= '0;
      stage_q     <= '0;
      res_cnt_q   <= '0;
      in_ready_q  <= 1'b0;
      tfm_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      tfm_en_q <= accept;
      done_q   <= 1'b0;
      if (accept) begin
        addr_hold_q <= addr_calc;
      end

      case (state_q)
        S_IDLE: begin
          // A stray result wins over the clear from a simultaneous start.
          err_q <= tfm_out_val | (err_q & ~start);
          if (start) begin
            state_q    <= S_RUN;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            bfly_q     <= '0;
            stage_q    <= '0;
            res_cnt_q  <= '0;
          end
        end

        S_RUN, S_DRAIN: begin
          if (tfm_out_val) begin
            if (res_full) begin
              err_q <= 1'b1;
            end else begin
              res_cnt_q <= res_cnt_q + RW'(1);
            end
          end
          if (accept) begin
            if (last_bfly) begin
              bfly_q <= '0;
              // Stage stays at its last value once the frame is fully issued.
              if (last_stage) begin
                state_q    <= S_DRAIN;
                in_ready_q <= 1'b0;
              end else begin
                stage_q <= stage_q + N_LOG2'(1);
              end
            end else begin
              bfly_q <= bfly_q + ADDR_WIDTH'(1);
            end
          end
          if (state_q == S_DRAIN && ((tfm_out_val && res_last) || res_full)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        S_DONE: begin
          if (tfm_out_val) begin
            err_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign rom_rd_en = accept;
  assign rom_addr  = accept ? addr_calc : addr_hold_q;
  assign tfm_en    = tfm_en_q;
  assign stage     = stage_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tfm_sched.sv
// Self-checking bench for tfm_sched (N = 8). A frame-level reference model
// (issue count, result count, address formula) predicts every output each
// cycle; a model multiplier returns a result 3 cycles after each accept.
module tb_tfm_sched;

  localparam int NL    = 3;
  localparam int N     = 1 << NL;
  localparam int HALF  = N / 2;
  localparam int TOTAL = NL * HALF;
  localparam int AW    = NL - 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          rom_rd_en;
  logic [AW-1:0] rom_addr;
  logic          tfm_en;
  logic          tfm_out_val;
  logic [NL-1:0] stage;
  logic          busy;
  logic          done;
  logic          err;

  int errors;
  int checks;

  // reference model
  bit       m_idle;
  bit       m_busy;
  bit       m_done;
  bit       m_err;
  bit       m_prev_acc;
  int       m_issued;
  int       m_results;
  int       m_last_addr;
  bit [2:0] pipe;
  bit       inj;
  int       cyc;
  int       done_cyc;
  int       gap;
  int       n_done;

  tfm_sched #(
    .N_LOG2      (NL),
    .ADDR_WIDTH  (AW),
    .TFM_LATENCY (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rom_rd_en   (rom_rd_en),
    .rom_addr    (rom_addr),
    .tfm_en      (tfm_en),
    .tfm_out_val (tfm_out_val),
    .stage       (stage),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Twiddle index for the k-th butterfly of the frame.
  function automatic int exp_addr(input int k);
    int s;
    int b;
    s = k / HALF;
    b = k % HALF;
    return (b % (N >> (s + 1))) * (1 << s);
  endfunction

  task automatic model_reset();
    m_idle      = 1'b1;
    m_busy      = 1'b0;
    m_done      = 1'b0;
    m_err       = 1'b0;
    m_prev_acc  = 1'b0;
    m_issued    = 0;
    m_results   = 0;
    m_last_addr = 0;
    pipe        = '0;
  endtask

  // One clock cycle: drive the multiplier, check all outputs, advance model.
  task automatic step();
    bit e_rdy;
    bit e_rd;
    int e_addr;
    int e_stage;
    bit was_idle;
    bit was_done;
    bit was_busy;
    bit err_set;

    tfm_out_val = pipe[2] | inj;
    @(negedge clk);
    e_rdy   = m_busy && (m_issued < TOTAL);
    e_rd    = e_rdy && in_valid;
    e_addr  = e_rd ? exp_addr(m_issued) : m_last_addr;
    e_stage = m_issued / HALF;
    if (e_stage > NL - 1) e_stage = NL - 1;

    check_eq("in_ready",  32'(in_ready),  32'(e_rdy));
    check_eq("rom_rd_en", 32'(rom_rd_en), 32'(e_rd));
    check_eq("rom_addr",  32'(rom_addr),  e_addr);
    check_eq("stage",     32'(stage),     e_stage);
    check_eq("tfm_en",    32'(tfm_en),    32'(m_prev_acc));
    check_eq("busy",      32'(busy),      32'(m_busy));
    check_eq("done",      32'(done),      32'(m_done));
    check_eq("err",       32'(err),       32'(m_err));

    if (done) begin
      done_cyc = cyc;
      n_done++;
    end
    if (rom_rd_en && done_cyc >= 0 && gap < 0) gap = cyc - done_cyc;

    if (!rst) begin
      model_reset();
    end else begin
      was_idle = m_idle;
      was_done = m_done;
      was_busy = m_busy;
      err_set  = tfm_out_val && (was_idle || was_done || m_results == TOTAL);
      if (was_idle && start) begin
        m_idle    = 1'b0;
        m_busy    = 1'b1;
        m_issued  = 0;
        m_results = 0;
        m_err     = 1'b0;
      end
      if (err_set) m_err = 1'b1;
      if (was_busy && tfm_out_val && m_results < TOTAL) begin
        m_results++;
        if (m_results == TOTAL) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
      if (was_done) begin
        m_done = 1'b0;
        m_idle = 1'b1;
      end
      if (e_rd) begin
        m_issued++;
        m_last_addr = e_addr;
      end
      m_prev_acc = e_rd;
      pipe = {pipe[1:0], e_rd};
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: in_valid held, 1: 1,0,0,1 pattern, 2: random
  task automatic drive_valid(input int mode, input int idx);
    case (mode)
      0:       in_valid = 1'b1;
      1:       in_valid = ((idx % 4) == 0) || ((idx % 4) == 3);
      default: in_valid = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_frame(input int mode, input int budget);
    bit finished;
    finished = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < budget; i++) begin
      drive_valid(mode, i);
      step();
      if (m_idle) begin
        finished = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!finished) check_eq("frame_timeout", 32'(m_idle), 32'd1);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    done_cyc = -1;
    gap      = -1;
    n_done   = 0;
    inj      = 1'b0;
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    tfm_out_val = 1'b0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b1;
    step();

    // full-rate frame, then gapped frame, then random frames
    run_frame(0, 200);
    check_eq("done_pulses_frame0", n_done, 1);
    run_frame(1, 300);
    for (int r = 0; r < 4; r++) run_frame(2, 400);

    // stray result in IDLE sets a sticky err, next start clears it
    inj = 1'b1;
    step();
    inj = 1'b0;
    repeat (3) step();
    check_eq("err_sticky", 32'(err), 32'd1);
    run_frame(0, 200);

    // reset after the 5th accept abandons the frame
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && m_issued < 5; i++) step();
    rst = 1'b0;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    check_eq("rst_busy", 32'(busy), 32'd0);
    run_frame(0, 200);

    // start held through the frame and the done cycle
    n_done   = 0;
    done_cyc = -1;
    gap      = -1;
    start    = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && gap < 0; i++) step();
    check_eq("restart_gap", gap, 2);
    check_eq("done_pulses_held", n_done, 1);
    start = 1'b0;
    for (int i = 0; i < 200 && !m_idle; i++) step();
    in_valid = 1'b0;
    step();
    check_eq("done_pulses_two", n_done, 2);
    check_eq("err_end", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tfm_sched.md
Name: tfm_sched

Overview:
- Sequencer for the radix-2 DIF FFT twiddle path.
- Accepts one butterfly operand per handshake and walks stage and butterfly counters.
- Issues the twiddle ROM read address and drives the enable of the twiddle factor multiplier (2-cycle latency, asserts out_val per result).
- Counts multiplier results and signals frame completion.

Parameters:
- N_LOG2, 6, log2 of FFT size N (N = 2**N_LOG2); legal range 2..12.
- ADDR_WIDTH, N_LOG2-1, twiddle ROM address width (ROM holds N/2 entries).
- TFM_LATENCY, 2, cycles from tfm en to tfm out_val; used only for drain accounting.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  frame start request; sampled only in IDLE.
- in_valid  in  1  upstream butterfly operand valid.
- in_ready  out  1  block accepts an operand this cycle.
- rom_rd_en  out  1  twiddle ROM read strobe.
- rom_addr  out  ADDR_WIDTH  twiddle ROM address.
- tfm_en  out  1  enable to the multiplier; aligned with ROM data (1-cycle ROM latency).
- tfm_out_val  in  1  result valid from the multiplier.
- stage  out  N_LOG2 bits  current issue stage, 0..N_LOG2-1.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when the last result of the frame is received.
- err  out  1  sticky; set by an unexpected tfm_out_val.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE. All outputs 0: in_ready, rom_rd_en, rom_addr, tfm_en, stage, busy, done, err. Internal counters cleared. A reset mid-frame abandons the frame with no done pulse.
- States and transitions:
  - IDLE: start=1 -> RUN; counters and err cleared.
  - RUN: in_ready=1; accept = in_valid & in_ready.
  - On the accept of the last butterfly (stage=N_LOG2-1, bfly=N/2-1): -> DRAIN, with in_ready=0 from the next cycle.
  - DRAIN: wait until res_cnt reaches TOTAL = N_LOG2*N/2 -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start outside IDLE is ignored.
- busy=1 in RUN and DRAIN; 0 in IDLE and DONE.
- Addressing:
  - rom_rd_en = accept (combinational).
  - rom_addr = (bfly & ((N>>(stage+1))-1)) << stage, computed from the current counters; valid while rom_rd_en=1, don't-care otherwise (hold last value).
  - stage 0 gives address = bfly; the final stage always gives address 0.
- Counters:
  - bfly is ADDR_WIDTH bits and increments on accept.
  - On wrap from N/2-1 to 0, stage increments.
  - in_valid gaps hold all counters; there is no penalty cycle.
- Alignment:
  - tfm_en is accept registered by one cycle; back-to-back accepts give a continuous tfm_en.
  - The multiplier result for an accept at cycle t is expected at t+1+TFM_LATENCY.
- Result counting:
  - res_cnt is wide enough for TOTAL and increments on tfm_out_val in RUN or DRAIN.
  - The transition to DONE happens in the cycle where res_cnt==TOTAL-1 and tfm_out_val=1; done asserts the next cycle.
- Error handling:
  - tfm_out_val in IDLE or DONE, or with res_cnt==TOTAL, sets err.
  - err is cleared only by reset or by a new start accepted in IDLE.
  - The block never stalls or aborts on err.
- Simultaneous events:
  - A final accept and a tfm_out_val in the same cycle are both honoured.
  - start asserted during the done cycle is ignored; it must be re-presented in IDLE.

Test Plan:
- N_LOG2=3, reset then start, in_valid held 1:
  - rom_addr sequence is 0,1,2,3 | 0,2,0,2 | 0,0,0,0 (12 accepts).
  - stage steps 0->1->2 on butterfly wrap.
  - in_ready drops after the 12th accept.
- Same frame with a model multiplier returning tfm_out_val 3 cycles after each accept:
  - done pulses exactly once, one cycle after the 12th tfm_out_val.
  - busy falls with done.
  - err=0.
- in_valid toggled 1,0,0,1 pattern: rom_addr and stage advance only on accept; tfm_en mirrors accepts delayed by exactly 1 cycle.
- Pulse tfm_out_val while in IDLE: err=1 and stays 1. The next start clears it to 0 in the cycle after start.
- rst=0 asserted after the 5th accept: all outputs 0 at the next edge and state=IDLE. A new start re-issues rom_addr from 0 at stage 0.
- start held high through the whole frame and the done cycle: exactly one frame runs. A second frame begins only after returning to IDLE with start still high (first accept possible 2 cycles after done).
